// File: rtl/mac_r_ram_rd_sched_if.sv
// Bundles the descriptor, RAM read port, data FIFO and pointer FIFO signals
// of the rx staging RAM read scheduler.
interface mac_r_ram_rd_sched_if #(
  parameter int AW = 11,
  parameter int LW = 13
);
  logic          desc_valid;
  logic          desc_ready;
  logic          desc_tte;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic          desc_crc_ok;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [7:0]    ram_dout;
  logic [11:0]   tte_fifo_depth;
  logic [11:0]   be_fifo_depth;
  logic          tteptr_full;
  logic          beptr_full;
  logic [7:0]    fifo_din;
  logic          tte_fifo_wr;
  logic          be_fifo_wr;
  logic [15:0]   ptr_din;
  logic          tteptr_wr;
  logic          beptr_wr;
  logic          busy;

  // Scheduler side.
  modport master (
    input  desc_valid, desc_tte, desc_addr, desc_len, desc_crc_ok,
    input  ram_dout, tte_fifo_depth, be_fifo_depth, tteptr_full, beptr_full,
    output desc_ready, ram_rd_en, ram_rd_addr, fifo_din,
    output tte_fifo_wr, be_fifo_wr, ptr_din, tteptr_wr, beptr_wr, busy
  );

  // Ingress writer, RAM and FIFO side.
  modport slave (
    output desc_valid, desc_tte, desc_addr, desc_len, desc_crc_ok,
    output ram_dout, tte_fifo_depth, be_fifo_depth, tteptr_full, beptr_full,
    input  desc_ready, ram_rd_en, ram_rd_addr, fifo_din,
    input  tte_fifo_wr, be_fifo_wr, ptr_din, tteptr_wr, beptr_wr, busy
  );
endinterface

// File: rtl/mac_r_ram_rd_sched.sv
// Read-side scheduler for the gmii rx staging RAM: per-class descriptor queues,
// TTE-first frame selection, single RAM read port streaming into the data FIFOs.
module mac_r_ram_rd_sched #(
  parameter int AW       = 11,
  parameter int LW       = 13,
  parameter int DQ_DEPTH = 4,
  parameter int FIFO_CAP = 4096,
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 1518
) (
  input logic                   rx_clk,
  input logic                   rstn,
  mac_r_ram_rd_sched_if.master  sched
);

  localparam int QAW = $clog2(DQ_DEPTH);
  localparam int EW  = AW + LW + 1;
  localparam logic [QAW:0]   Q_FULL  = (QAW+1)'(DQ_DEPTH);
  localparam logic [QAW-1:0] Q_ONE   = QAW'(1);
  localparam logic [QAW:0]   C_ONE   = (QAW+1)'(1);
  localparam logic [LW:0]    CAP     = (LW+1)'(FIFO_CAP);
  localparam logic [LW-1:0]  LEN_MIN = LW'(MIN_LEN);
  localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0]  LEN_ONE = LW'(1);
  localparam logic [AW-1:0]  A_ONE   = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_DRAIN,
    S_PTR
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [EW-1:0] r_tteMem [DQ_DEPTH];
  logic [EW-1:0] r_beMem  [DQ_DEPTH];
  logic [QAW-1:0] r_tteWp, r_tteRp, r_beWp, r_beRp;
  logic [QAW:0]   r_tteCnt, r_beCnt;

  logic          r_selTte;
  logic [AW-1:0] r_rdAddr;
  logic [LW-1:0] r_remaining;
  logic [LW-1:0] r_len;
  logic          r_crcOk;
  logic          r_drainCnt;
  logic          r_rdEn1;
  logic          r_rdEn2;
  logic [7:0]    r_fifoDin;

  logic          w_tteFull, w_beFull;
  logic          w_ttePush, w_bePush;
  logic          w_popTte, w_popBe;
  logic [EW-1:0] w_head;
  logic [11:0]   w_selDepth;
  logic [LW:0]   w_sum;
  logic          w_canGo;
  logic          w_rdEn;
  logic          w_lenBad;

  assign w_tteFull = (r_tteCnt == Q_FULL);
  assign w_beFull  = (r_beCnt == Q_FULL);
  assign sched.desc_ready = sched.desc_tte ? !w_tteFull : !w_beFull;
  assign w_ttePush = sched.desc_valid && sched.desc_ready && sched.desc_tte;
  assign w_bePush  = sched.desc_valid && sched.desc_ready && !sched.desc_tte;

  assign w_head     = w_popTte ? r_tteMem[r_tteRp] : r_beMem[r_beRp];
  assign w_selDepth = r_selTte ? sched.tte_fifo_depth : sched.be_fifo_depth;
  assign w_sum      = {{(LW+1-12){1'b0}}, w_selDepth} + {1'b0, r_len};
  assign w_canGo    = (w_sum <= CAP) && !(r_selTte ? sched.tteptr_full : sched.beptr_full);
  assign w_rdEn     = (r_state == S_READ);
  assign w_lenBad   = (r_len < LEN_MIN) || (r_len > LEN_MAX);

  // Queue storage carries no reset; only pointers and counts define occupancy.
  always_ff @(posedge rx_clk) begin
    if (w_ttePush) r_tteMem[r_tteWp] <= {sched.desc_addr, sched.desc_len, sched.desc_crc_ok};
    if (w_bePush)  r_beMem[r_beWp]   <= {sched.desc_addr, sched.desc_len, sched.desc_crc_ok};
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      r_tteWp  <= '0;
      r_tteRp  <= '0;
      r_tteCnt <= '0;
      r_beWp   <= '0;
      r_beRp   <= '0;
      r_beCnt  <= '0;
    end else begin
      if (w_ttePush) r_tteWp <= r_tteWp + Q_ONE;
      if (w_popTte)  r_tteRp <= r_tteRp + Q_ONE;
      if (w_ttePush && !w_popTte) r_tteCnt <= r_tteCnt + C_ONE;
      else if (!w_ttePush && w_popTte) r_tteCnt <= r_tteCnt - C_ONE;
      if (w_bePush) r_beWp <= r_beWp + Q_ONE;
      if (w_popBe)  r_beRp <= r_beRp + Q_ONE;
      if (w_bePush && !w_popBe) r_beCnt <= r_beCnt + C_ONE;
      else if (!w_bePush && w_popBe) r_beCnt <= r_beCnt - C_ONE;
    end
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_popTte    = 1'b0;
    w_popBe     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tteCnt != '0) begin
          w_popTte    = 1'b1;
          w_nextState = S_CHECK;
        end else if (r_beCnt != '0) begin
          w_popBe     = 1'b1;
          w_nextState = S_CHECK;
        end
      end
      // Head-of-line blocking on FIFO space or pointer full is deliberate.
      S_CHECK: begin
        if (w_canGo) w_nextState = (r_len == '0) ? S_PTR : S_READ;
      end
      S_READ: begin
        if (r_remaining == LEN_ONE) w_nextState = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drainCnt) w_nextState = S_PTR;
      end
      S_PTR:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Working registers load on pop; the read address and remaining count
  // are primed here so READ can strobe from its very first cycle.
  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      r_selTte    <= 1'b0;
      r_rdAddr    <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_crcOk     <= 1'b0;
      r_drainCnt  <= 1'b0;
      r_rdEn1     <= 1'b0;
      r_rdEn2     <= 1'b0;
      r_fifoDin   <= '0;
    end else begin
      if (w_popTte || w_popBe) begin
        r_selTte    <= w_popTte;
        r_rdAddr    <= w_head[EW-1 -: AW];
        r_remaining <= w_head[LW:1];
        r_len       <= w_head[LW:1];
        r_crcOk     <= w_head[0];
      end else if (r_state == S_READ) begin
        r_rdAddr    <= r_rdAddr + A_ONE;
        r_remaining <= r_remaining - LEN_ONE;
      end
      r_drainCnt <= (r_state == S_DRAIN) ? !r_drainCnt : 1'b0;
      r_rdEn1    <= w_rdEn;
      r_rdEn2    <= r_rdEn1;
      r_fifoDin  <= sched.ram_dout;
    end
  end

  assign sched.ram_rd_en   = w_rdEn;
  assign sched.ram_rd_addr = w_rdEn ? r_rdAddr : '0;
  assign sched.fifo_din    = r_fifoDin;
  assign sched.tte_fifo_wr = r_rdEn2 && r_selTte;
  assign sched.be_fifo_wr  = r_rdEn2 && !r_selTte;
  assign sched.ptr_din     = (r_state == S_PTR) ? {!r_crcOk, w_lenBad, 1'b0, r_len} : 16'h0000;
  assign sched.tteptr_wr   = (r_state == S_PTR) && r_selTte;
  assign sched.beptr_wr    = (r_state == S_PTR) && !r_selTte;
  assign sched.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mac_r_ram_rd_sched.sv
// Directed self-checking bench for mac_r_ram_rd_sched with a behavioural RAM
// and monitors logging reads, FIFO writes and pointer writes.
module tb_mac_r_ram_rd_sched;

  logic rx_clk = 1'b0;
  logic rstn   = 1'b0;
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;

  mac_r_ram_rd_sched_if #(.AW(11), .LW(13)) bus ();

  mac_r_ram_rd_sched #(.AW(11), .LW(13), .DQ_DEPTH(4), .FIFO_CAP(4096),
                       .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .rx_clk (rx_clk),
    .rstn   (rstn),
    .sched  (bus)
  );

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  function automatic logic [7:0] ramByte(input logic [10:0] a);
    return a[7:0] ^ {5'b00000, a[10:8]} ^ 8'hA5;
  endfunction

  always @(posedge rx_clk) begin
    if (bus.ram_rd_en) bus.ram_dout <= ramByte(bus.ram_rd_addr);
  end

  logic [10:0] rdLog[$];
  logic [7:0]  expData[$];
  logic [17:0] ptrLog[$];
  int          ptrCycLog[$];
  int firstRdCyc, lastRdCyc, firstWrCyc, firstTteWrCyc, beWr, tteWr, dataErr;

  // Monitor: reads, data bytes (checked against the RAM model) and pointer writes.
  always @(negedge rx_clk) begin
    if (rstn) begin
      if (bus.ram_rd_en) begin
        if (rdLog.size() == 0) firstRdCyc = cyc;
        lastRdCyc = cyc;
        rdLog.push_back(bus.ram_rd_addr);
        expData.push_back(ramByte(bus.ram_rd_addr));
      end
      if (bus.be_fifo_wr || bus.tte_fifo_wr) begin
        if (expData.size() == 0) dataErr++;
        else begin
          if (bus.fifo_din !== expData[0]) dataErr++;
          void'(expData.pop_front());
        end
        if (bus.be_fifo_wr && bus.tte_fifo_wr) dataErr++;
        if (firstWrCyc < 0) firstWrCyc = cyc;
        if (bus.be_fifo_wr) beWr++;
        if (bus.tte_fifo_wr) begin
          tteWr++;
          if (firstTteWrCyc < 0) firstTteWrCyc = cyc;
        end
      end
      if (bus.tteptr_wr || bus.beptr_wr) begin
        ptrLog.push_back({bus.tteptr_wr, bus.beptr_wr, bus.ptr_din});
        ptrCycLog.push_back(cyc);
      end
    end
  end

  function automatic logic [17:0] getPtr(input int i);
    if (i < ptrLog.size()) return ptrLog[i];
    return 18'h3FFFF;
  endfunction

  function automatic int ptrCycAt(input int i);
    if (i < ptrCycLog.size()) return ptrCycLog[i];
    return -1000;
  endfunction

  function automatic logic [10:0] rdAt(input int i);
    if (i < rdLog.size()) return rdLog[i];
    return 11'h7FF;
  endfunction

  function automatic logic [17:0] bePtr(input logic [15:0] w);
    return {2'b01, w};
  endfunction

  function automatic logic [17:0] ttePtr(input logic [15:0] w);
    return {2'b10, w};
  endfunction

  task automatic clearLogs();
    rdLog.delete();
    expData.delete();
    ptrLog.delete();
    ptrCycLog.delete();
    firstRdCyc    = -1;
    lastRdCyc     = -1;
    firstWrCyc    = -1;
    firstTteWrCyc = -1;
    beWr          = 0;
    tteWr         = 0;
    dataErr       = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic tte, input logic [10:0] addr, input logic [12:0] len,
                               input logic crc, output logic rdy);
    bus.desc_valid  = 1'b1;
    bus.desc_tte    = tte;
    bus.desc_addr   = addr;
    bus.desc_len    = len;
    bus.desc_crc_ok = crc;
    #1;
    rdy = bus.desc_ready;
    @(posedge rx_clk);
    #1;
    bus.desc_valid = 1'b0;
    bus.desc_tte   = 1'b0;
  endtask

  task automatic waitPtrs(input int n, input int budget, input string tag);
    int k = 0;
    while (ptrLog.size() < n && k < budget) begin
      @(posedge rx_clk);
      #1;
      k++;
    end
    checkOutput(tag, ptrLog.size(), n);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ready"}, bus.desc_ready, 1);
    checkOutput({tag, "_strobes"}, {bus.ram_rd_en, bus.tte_fifo_wr, bus.be_fifo_wr,
                                    bus.tteptr_wr, bus.beptr_wr, bus.busy}, 0);
    checkOutput({tag, "_rdaddr"}, bus.ram_rd_addr, 0);
    checkOutput({tag, "_fifodin"}, bus.fifo_din, 0);
    checkOutput({tag, "_ptrdin"}, bus.ptr_din, 0);
  endtask

  initial begin
    logic r, r1, r2, r3, r4, r5;
    int seqErr;
    int k;
    bus.desc_valid     = 1'b0;
    bus.desc_tte       = 1'b0;
    bus.desc_addr      = '0;
    bus.desc_len       = '0;
    bus.desc_crc_ok    = 1'b0;
    bus.ram_dout       = 8'h00;
    bus.tte_fifo_depth = 12'd0;
    bus.be_fifo_depth  = 12'd0;
    bus.tteptr_full    = 1'b0;
    bus.beptr_full     = 1'b0;
    clearLogs();

    #3;
    checkQuiet("reset");
    waitCycles(2);
    rstn = 1'b1;
    waitCycles(2);
    checkQuiet("post_reset");

    $display("[TB] single BE frame");
    clearLogs();
    applyStimulus(1'b0, 11'h010, 13'd64, 1'b1, r);
    checkOutput("t1_ready", r, 1);
    waitPtrs(1, 300, "t1_ptr_count");
    waitCycles(2);
    checkOutput("t1_rd_count", rdLog.size(), 64);
    seqErr = 0;
    for (int i = 0; i < 64; i++) if (rdAt(i) !== 11'(16 + i)) seqErr++;
    checkOutput("t1_addr_seq", seqErr, 0);
    checkOutput("t1_back_to_back", lastRdCyc - firstRdCyc, 63);
    checkOutput("t1_be_wr", beWr, 64);
    checkOutput("t1_tte_wr", tteWr, 0);
    checkOutput("t1_latency", firstWrCyc - firstRdCyc, 2);
    checkOutput("t1_data", dataErr, 0);
    checkOutput("t1_ptr", getPtr(0), bePtr(16'h0040));
    checkOutput("t1_ptr_time", ptrCycAt(0) - lastRdCyc, 3);

    $display("[TB] TTE priority over queued BE");
    clearLogs();
    bus.beptr_full = 1'b1;
    applyStimulus(1'b0, 11'h300, 13'd8, 1'b1, r);
    waitCycles(15);
    checkOutput("t2_hold_ptrfull_rd", rdLog.size(), 0);
    checkOutput("t2_hold_busy", bus.busy, 1);
    applyStimulus(1'b0, 11'h310, 13'd16, 1'b1, r);
    applyStimulus(1'b1, 11'h320, 13'd8, 1'b1, r);
    bus.beptr_full = 1'b0;
    waitPtrs(3, 200, "t2_ptr_count");
    checkOutput("t2_ptr0", getPtr(0), bePtr(16'h4008));
    checkOutput("t2_ptr1", getPtr(1), ttePtr(16'h4008));
    checkOutput("t2_ptr2", getPtr(2), bePtr(16'h4010));
    checkOutput("t2_tte_first_rd", rdAt(8), 11'h320);
    checkOutput("t2_be2_first_rd", rdAt(16), 11'h310);

    $display("[TB] TTE arrival during BE frame");
    clearLogs();
    applyStimulus(1'b0, 11'h100, 13'd1000, 1'b1, r);
    waitCycles(100);
    applyStimulus(1'b1, 11'h020, 13'd64, 1'b1, r);
    waitPtrs(2, 1300, "t3_ptr_count");
    waitCycles(2);
    checkOutput("t3_ptr0", getPtr(0), bePtr(16'h03E8));
    checkOutput("t3_ptr1", getPtr(1), ttePtr(16'h0040));
    checkOutput("t3_tte_start", firstTteWrCyc - ptrCycAt(0), 5);
    checkOutput("t3_be_wr", beWr, 1000);
    checkOutput("t3_tte_wr", tteWr, 64);
    checkOutput("t3_be_last_rd", rdAt(999), 11'h4E7);
    checkOutput("t3_tte_first_rd", rdAt(1000), 11'h020);
    checkOutput("t3_data", dataErr, 0);

    $display("[TB] FIFO space backpressure");
    clearLogs();
    bus.be_fifo_depth = 12'd3100;
    applyStimulus(1'b0, 11'h000, 13'd1000, 1'b1, r);
    waitCycles(20);
    checkOutput("t4_hold_rd", rdLog.size(), 0);
    checkOutput("t4_hold_busy", bus.busy, 1);
    bus.be_fifo_depth = 12'd3097;
    waitCycles(5);
    checkOutput("t4_hold_4097", rdLog.size(), 0);
    bus.be_fifo_depth = 12'd3096;
    k = cyc;
    waitPtrs(1, 1100, "t4_ptr_count");
    bus.be_fifo_depth = 12'd0;
    checkOutput("t4_release_time", firstRdCyc, k + 1);
    checkOutput("t4_ptr", getPtr(0), bePtr(16'h03E8));

    $display("[TB] edge descriptors");
    clearLogs();
    applyStimulus(1'b0, 11'h200, 13'd60, 1'b0, r);
    waitPtrs(1, 200, "t5a_ptr_count");
    checkOutput("t5a_ptr", getPtr(0), bePtr(16'hC03C));
    checkOutput("t5a_rd", rdLog.size(), 60);

    clearLogs();
    applyStimulus(1'b1, 11'h055, 13'd0, 1'b1, r);
    waitPtrs(1, 50, "t5b_ptr_count");
    waitCycles(3);
    checkOutput("t5b_ptr", getPtr(0), ttePtr(16'h4000));
    checkOutput("t5b_rd", rdLog.size(), 0);
    checkOutput("t5b_wr", beWr + tteWr, 0);

    clearLogs();
    applyStimulus(1'b0, 11'd2046, 13'd4, 1'b1, r);
    waitPtrs(1, 50, "t5c_ptr_count");
    checkOutput("t5c_rd_count", rdLog.size(), 4);
    checkOutput("t5c_rd_addrs", {rdAt(0), rdAt(1), rdAt(2), rdAt(3)},
                {11'd2046, 11'd2047, 11'd0, 11'd1});
    checkOutput("t5c_ptr", getPtr(0), bePtr(16'h4004));
    checkOutput("t5c_data", dataErr, 0);

    clearLogs();
    applyStimulus(1'b0, 11'h000, 13'd1519, 1'b1, r);
    waitPtrs(1, 1700, "t5d_ptr_count");
    checkOutput("t5d_ptr", getPtr(0), bePtr(16'h45EF));

    $display("[TB] queue full and mid-read reset");
    clearLogs();
    bus.tteptr_full = 1'b1;
    applyStimulus(1'b1, 11'h400, 13'd200, 1'b1, r);
    waitCycles(3);
    applyStimulus(1'b0, 11'h010, 13'd64, 1'b1, r1);
    applyStimulus(1'b0, 11'h020, 13'd64, 1'b1, r2);
    applyStimulus(1'b0, 11'h030, 13'd64, 1'b1, r3);
    applyStimulus(1'b0, 11'h040, 13'd64, 1'b1, r4);
    applyStimulus(1'b0, 11'h050, 13'd64, 1'b1, r5);
    checkOutput("t6_ready_1to4", {r1, r2, r3, r4}, 4'hF);
    checkOutput("t6_ready_5th", r5, 0);
    checkOutput("t6_no_reads", rdLog.size(), 0);
    bus.tteptr_full = 1'b0;
    waitCycles(10);
    checkOutput("t6_mid_read", bus.ram_rd_en, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkQuiet("t6_async_reset");
    waitCycles(2);
    rstn = 1'b1;
    clearLogs();
    waitCycles(30);
    checkOutput("t6_flush_rd", rdLog.size(), 0);
    checkOutput("t6_flush_ptr", ptrLog.size(), 0);
    checkOutput("t6_flush_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
